// File: rtl/toggle_line_decoder.sv
// Recovers T-flip-flop encoded bits from an async line and frames them into words.
// Optional even-parity bit when TOGGLE_DEC_PARITY_EN is defined.
module toggle_line_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              line_in,
  output logic [DATA_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  toggle_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic               sync1_q, line_s;
  logic               prev_q, prev_vld_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  shift_q;
  logic               bit_vld, t;
  logic               commit, frame_bad;
`ifdef TOGGLE_DEC_PARITY_EN
  logic               par_q, par_bad, par_mis;
  assign par_mis = ^{shift_q, par_q};
`endif

  assign bit_vld = sample_en & prev_vld_q;
  assign t       = line_s ^ prev_q;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      line_s     <= 1'b0;
      prev_q     <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      sync1_q <= line_in;
      line_s  <= sync1_q;
      if (sample_en) begin
        prev_q     <= line_s;
        prev_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    frame_bad = 1'b0;
`ifdef TOGGLE_DEC_PARITY_EN
    par_bad   = 1'b0;
`endif
    if (bit_vld) begin
      case (state_q)
        IDLE:   if (t) state_d = DATA;
        DATA: begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef TOGGLE_DEC_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          // A bad stop bit masks any parity result.
          if (t) frame_bad = 1'b1;
`ifdef TOGGLE_DEC_PARITY_EN
          else if (par_mis) par_bad = 1'b1;
`endif
          else commit = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      shift_q      <= '0;
      toggle_count <= '0;
      frame_err    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (bit_vld && t) toggle_count <= toggle_count + CNT_W'(1);
      if (bit_vld) begin
        case (state_q)
          IDLE: if (t) begin
            idx_q   <= '0;
            shift_q <= '0;
          end
          DATA: begin
            shift_q[idx_q] <= t;
            idx_q          <= idx_q + IDX_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TOGGLE_DEC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_bad;
      if (bit_vld && state_q == PARITY) par_q <= t;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // A same-cycle handshake frees the buffer for the incoming word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit && (!word_valid || word_ready)) begin
      word_data  <= shift_q;
      word_valid <= 1'b1;
    end else begin
      if (commit) overrun <= 1'b1;
      if (word_valid && word_ready) word_valid <= 1'b0;
    end
  end

endmodule
